// File: rtl/bram_rd_arbiter_if.sv
// Read-port bundle between both clients, the arbiter and BRAM port 0.
// Ports: core req/addr/gnt/valid/data/err, same for renderer, BRAM addr0/ce0/we0/q0.
// slave = arbiter side, master = client + BRAM side.
interface bram_rd_arbiter_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 4
);
    logic              i_core_req;
    logic [AWIDTH-1:0] i_core_addr;
    logic              o_core_gnt;
    logic              o_core_valid;
    logic [DWIDTH-1:0] o_core_data;
    logic              o_core_err;

    logic              i_rend_req;
    logic [AWIDTH-1:0] i_rend_addr;
    logic              o_rend_gnt;
    logic              o_rend_valid;
    logic [DWIDTH-1:0] o_rend_data;
    logic              o_rend_err;

    logic [AWIDTH-1:0] o_bram_addr0;
    logic              o_bram_ce0;
    logic              o_bram_we0;
    logic [DWIDTH-1:0] i_bram_q0;

    modport slave (
        input  i_core_req, i_core_addr,
        output o_core_gnt, o_core_valid, o_core_data, o_core_err,
        input  i_rend_req, i_rend_addr,
        output o_rend_gnt, o_rend_valid, o_rend_data, o_rend_err,
        output o_bram_addr0, o_bram_ce0, o_bram_we0,
        input  i_bram_q0
    );

    modport master (
        output i_core_req, i_core_addr,
        input  o_core_gnt, o_core_valid, o_core_data, o_core_err,
        output i_rend_req, i_rend_addr,
        input  o_rend_gnt, o_rend_valid, o_rend_data, o_rend_err,
        input  o_bram_addr0, o_bram_ce0, o_bram_we0,
        output i_bram_q0
    );
endinterface

// File: rtl/bram_rd_arbiter.sv
// Core/renderer read arbiter for tetromino BRAM port 0, fixed 2-cycle return.
// Ports: s00_axi_aclk, s00_axi_aresetn (async, active-low), bus (slave modport).
// Macro BRAM_RD_ARB_STARVE_GUARD_EN adds the renderer starvation guard.
module bram_rd_arbiter #(
    parameter int DWIDTH       = 32,
    parameter int AWIDTH       = 4,
    parameter int MEM_DEPTH    = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             s00_axi_aclk,
    input  logic             s00_axi_aresetn,
    bram_rd_arbiter_if.slave bus
);
    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_REND = 1'b1;
    localparam logic [AWIDTH:0] DEPTH = (AWIDTH + 1)'(MEM_DEPTH);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("STARVE_LIMIT out of range");
    end

    logic              core_ok;
    logic              rend_ok;
    logic              force_rend;
    logic              core_win;
    logic              rend_win;
    logic              any_win;
    logic [AWIDTH-1:0] win_addr;
    logic              win_err;
    logic [AWIDTH-1:0] addr_q;
    logic              s1_valid;
    logic              s1_owner;
    logic              s1_err;
    logic [DWIDTH-1:0] ret_data;

    assign core_ok = {1'b0, bus.i_core_addr} < DEPTH;
    assign rend_ok = {1'b0, bus.i_rend_addr} < DEPTH;

`ifdef BRAM_RD_ARB_STARVE_GUARD_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;

    assign force_rend = (starve_cnt == LIMIT);

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            starve_cnt <= '0;
        end else if (bus.i_rend_req && !rend_win) begin
            starve_cnt <= force_rend ? LIMIT : starve_cnt + 4'd1;
        end else begin
            starve_cnt <= '0;
        end
    end
`else
    assign force_rend = 1'b0;
`endif

    // Reset gates the grants so a held req is ignored until release.
    assign core_win = s00_axi_aresetn && bus.i_core_req
                   && !(bus.i_rend_req && force_rend);
    assign rend_win = s00_axi_aresetn && bus.i_rend_req && !core_win;
    assign any_win  = core_win || rend_win;

    assign win_addr = core_win ? bus.i_core_addr : bus.i_rend_addr;
    assign win_err  = core_win ? !core_ok : !rend_ok;

    assign bus.o_core_gnt   = core_win;
    assign bus.o_rend_gnt   = rend_win;
    assign bus.o_bram_ce0   = any_win && !win_err;
    assign bus.o_bram_addr0 = any_win ? win_addr : addr_q;
    assign bus.o_bram_we0   = 1'b0;

    // Stage 1: tag for the cycle in which the BRAM performs the read.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            addr_q   <= '0;
            s1_valid <= 1'b0;
            s1_owner <= OWN_CORE;
            s1_err   <= 1'b0;
        end else begin
            if (any_win) begin
                addr_q <= win_addr;
            end
            s1_valid <= any_win;
            s1_owner <= rend_win ? OWN_REND : OWN_CORE;
            s1_err   <= win_err;
        end
    end

    assign ret_data = s1_err ? '0 : bus.i_bram_q0;

    // Stage 2: steer the returned word to its owner; data holds otherwise.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            bus.o_core_valid <= 1'b0;
            bus.o_core_err   <= 1'b0;
            bus.o_core_data  <= '0;
            bus.o_rend_valid <= 1'b0;
            bus.o_rend_err   <= 1'b0;
            bus.o_rend_data  <= '0;
        end else begin
            bus.o_core_valid <= s1_valid && (s1_owner == OWN_CORE);
            bus.o_core_err   <= s1_valid && (s1_owner == OWN_CORE) && s1_err;
            bus.o_rend_valid <= s1_valid && (s1_owner == OWN_REND);
            bus.o_rend_err   <= s1_valid && (s1_owner == OWN_REND) && s1_err;
            if (s1_valid && (s1_owner == OWN_CORE)) begin
                bus.o_core_data <= ret_data;
            end
            if (s1_valid && (s1_owner == OWN_REND)) begin
                bus.o_rend_data <= ret_data;
            end
        end
    end
endmodule
